// File: rtl/alu_flags_irq_pkg.sv
// -----------------------------------------------------------------------------
// alu_flags_irq_pkg
//   Shared definitions for the ALU flags / overflow-trap block:
//     - bit positions of N/V/C/Z inside the 4-bit flags word
//     - encodings of the trap-handshake FSM states
//     - make_flags(): packs individual condition bits into a flags word
//   Configuration macro ALU_FLAGS_STICKY_EN is consumed by the top module only.
// -----------------------------------------------------------------------------
package alu_flags_irq_pkg;

  // Flags word layout: {N, V, C, Z}
  localparam int FLAG_N = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

  // Trap-handshake FSM encodings
  localparam logic [1:0] FLG_IDLE = 2'd0;
  localparam logic [1:0] FLG_REQ  = 2'd1;
  localparam logic [1:0] FLG_SVC  = 2'd2;

  function automatic logic [3:0] make_flags(input logic n, input logic v,
                                            input logic c, input logic z);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_flags_irq_flag_stack.sv
// -----------------------------------------------------------------------------
// flag_stack
//   DEPTH-entry LIFO of 4-bit flag words used to save the architectural flags
//   across (nested) trap handlers.
//   Ports:
//     clk, reset_n  clock, asynchronous active-low reset (clears depth only)
//     push          write din on top (ignored when full)
//     pop           discard top (ignored when empty)
//     din           flags word to save
//     dout          current top-of-stack (valid when !empty)
//     full, empty   occupancy status
//     depth         registered number of valid entries
// -----------------------------------------------------------------------------
module flag_stack #(
  parameter int DEPTH   = 2,
  parameter int DEPTH_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push,
  input  logic               pop,
  input  logic [3:0]         din,
  output logic [3:0]         dout,
  output logic               full,
  output logic               empty,
  output logic [DEPTH_W-1:0] depth
);

  // Storage is sized to the full index range of depth so any depth value
  // indexes it without width truncation; entries at DEPTH and above are
  // never written.
  logic [3:0]         r_mem [2**DEPTH_W];
  logic [DEPTH_W-1:0] r_depth;
  logic               w_do_push;
  logic               w_do_pop;

  assign full      = (r_depth == DEPTH_W'(DEPTH));
  assign empty     = (r_depth == '0);
  assign depth     = r_depth;
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign dout      = r_mem[r_depth - DEPTH_W'(1)];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_depth <= '0;
    end else if (w_do_push) begin
      r_depth <= r_depth + DEPTH_W'(1);
    end else if (w_do_pop) begin
      r_depth <= r_depth - DEPTH_W'(1);
    end
  end

  // NOTE: the storage array has no reset; its contents are only read below
  // depth, which reset clears, so resetting it would buy nothing.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_depth] <= din;
    end
  end

endmodule

// File: rtl/alu_flags_irq.sv
// -----------------------------------------------------------------------------
// alu_flags_irq
//   Consumer side of the ALU result interface. Holds the architectural N/V/C/Z
//   flags, raises an overflow trap to the interrupt controller over irq_req /
//   irq_ack, and saves/restores flags around nested handlers on a LIFO.
//   Ports:
//     clk, reset_n        clock, asynchronous active-low reset
//     alu_out             ALU result; N is taken from its MSB
//     alu_zero/carry/
//     alu_overflow        ALU condition outputs
//     flags_we            load flags from the ALU this cycle
//     trap_en             enable the overflow trap
//     sw_wr, sw_wdata     software write of {N,V,C,Z}
//     eret                handler return: pop and restore flags
//     irq_ack             interrupt controller accepts the request
//     flags               {N,V,C,Z}
//     irq_req             overflow trap request (registered)
//     in_handler          save depth non-zero
//     stack_err           sticky push-overflow / pop-underflow error
//     sticky_ovf          only with ALU_FLAGS_STICKY_EN: sticky overflow seen
//   Write priority on each edge: eret restore > sw_wr > flags_we.
//   Optional feature macro: ALU_FLAGS_STICKY_EN.
// -----------------------------------------------------------------------------
module alu_flags_irq
  import alu_flags_irq_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int STACK_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              flags_we,
  input  logic              trap_en,
  input  logic              sw_wr,
  input  logic [3:0]        sw_wdata,
  input  logic              eret,
  input  logic              irq_ack,
  output logic [3:0]        flags,
  output logic              irq_req,
  output logic              in_handler,
  output logic              stack_err
`ifdef ALU_FLAGS_STICKY_EN
  ,
  output logic              sticky_ovf
`endif
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [3:0]         r_flags;
  logic [3:0]         w_flags_nxt;
  logic               r_stack_err;
  logic               w_trap;
  logic               w_ack;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [3:0]         w_top;
  logic [DEPTH_W-1:0] w_depth;
  logic               w_unused_alu;

  // Only the sign bit of the result feeds the flags.
  assign w_unused_alu = ^alu_out[DATA_W-2:0];

  // A trap is only recognised when flags_we actually wins the flags write,
  // and never while a request is already outstanding.
  assign w_trap = flags_we & alu_overflow & trap_en & ~eret & ~sw_wr &
                  ((r_state == FLG_IDLE) | (r_state == FLG_SVC));

  // eret in REQ takes the edge; the acknowledge is ignored until a later one.
  assign w_ack  = (r_state == FLG_REQ) & irq_ack & ~eret;
  assign w_pop  = eret & ~w_empty;

  flag_stack #(
    .DEPTH   (STACK_DEPTH),
    .DEPTH_W (DEPTH_W)
  ) u_flag_stack (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_ack),
    .pop     (w_pop),
    .din     (r_flags),
    .dout    (w_top),
    .full    (w_full),
    .empty   (w_empty),
    .depth   (w_depth)
  );

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_flags_nxt = r_flags;
    if (eret) begin
      if (!w_empty) begin
        w_flags_nxt = w_top;
      end
    end else if (sw_wr) begin
      w_flags_nxt = sw_wdata;
    end else if (flags_we) begin
      w_flags_nxt = make_flags(alu_out[DATA_W-1], alu_overflow, alu_carry,
                               alu_zero);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FLG_IDLE: begin
        if (w_trap) begin
          w_state_nxt = FLG_REQ;
        end
      end
      FLG_REQ: begin
        // A full stack drops the push, but the handler is still entered.
        if (w_ack) begin
          w_state_nxt = FLG_SVC;
        end
      end
      FLG_SVC: begin
        if (eret) begin
          if (w_pop && (w_depth == DEPTH_W'(1))) begin
            w_state_nxt = FLG_IDLE;
          end
        end else if (w_trap) begin
          w_state_nxt = FLG_REQ;
        end
      end
      default: w_state_nxt = FLG_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= FLG_IDLE;
      r_flags     <= '0;
      r_stack_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flags     <= w_flags_nxt;
      if ((w_ack && w_full) || (eret && w_empty)) begin
        r_stack_err <= 1'b1;
      end
    end
  end

  assign flags      = r_flags;
  assign irq_req    = (r_state == FLG_REQ);
  assign in_handler = (w_depth != '0);
  assign stack_err  = r_stack_err;

`ifdef ALU_FLAGS_STICKY_EN
  logic r_sticky_ovf;

  // Clearing needs a software write that is not overridden by eret.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sticky_ovf <= 1'b0;
    end else if (sw_wr && !eret && !sw_wdata[FLAG_V]) begin
      r_sticky_ovf <= 1'b0;
    end else if (flags_we && alu_overflow) begin
      r_sticky_ovf <= 1'b1;
    end
  end

  assign sticky_ovf = r_sticky_ovf;
`endif

endmodule

// File: tb/tb_alu_flags_irq.sv
// -----------------------------------------------------------------------------
// tb_alu_flags_irq
//   Directed self-checking bench for alu_flags_irq (DATA_W=16, STACK_DEPTH=2).
//   Inputs change just after the falling edge; outputs are checked at the
//   falling edge following each rising edge.
// -----------------------------------------------------------------------------
module tb_alu_flags_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] alu_out;
  logic        alu_zero;
  logic        alu_carry;
  logic        alu_overflow;
  logic        flags_we;
  logic        trap_en;
  logic        sw_wr;
  logic [3:0]  sw_wdata;
  logic        eret;
  logic        irq_ack;
  logic [3:0]  flags;
  logic        irq_req;
  logic        in_handler;
  logic        stack_err;
`ifdef ALU_FLAGS_STICKY_EN
  logic        sticky_ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_flags_irq #(
    .DATA_W      (16),
    .STACK_DEPTH (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .alu_out      (alu_out),
    .alu_zero     (alu_zero),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .flags_we     (flags_we),
    .trap_en      (trap_en),
    .sw_wr        (sw_wr),
    .sw_wdata     (sw_wdata),
    .eret         (eret),
    .irq_ack      (irq_ack),
    .flags        (flags),
    .irq_req      (irq_req),
    .in_handler   (in_handler),
    .stack_err    (stack_err)
`ifdef ALU_FLAGS_STICKY_EN
    ,
    .sticky_ovf   (sticky_ovf)
`endif
  );

  task automatic check(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clr();
    alu_out      = '0;
    alu_zero     = 1'b0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    flags_we     = 1'b0;
    trap_en      = 1'b0;
    sw_wr        = 1'b0;
    sw_wdata     = '0;
    eret         = 1'b0;
    irq_ack      = 1'b0;
  endtask

  task automatic alu(input logic [15:0] o, input logic z, input logic c,
                     input logic v, input logic ten);
    alu_out      = o;
    alu_zero     = z;
    alu_carry    = c;
    alu_overflow = v;
    flags_we     = 1'b1;
    trap_en      = ten;
  endtask

  // One rising edge, then settle at the falling edge for checking.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    clr();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: reset asserted while a request is outstanding
    alu(16'h8000, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    clr();
    check("pre_reset_req", {3'b0, irq_req}, 4'b0001);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_flags", flags, 4'b0000);
    check("rst_async_req", {3'b0, irq_req}, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("rst_flags", flags, 4'b0000);
    check("rst_req", {3'b0, irq_req}, 4'b0000);
    check("rst_in_handler", {3'b0, in_handler}, 4'b0000);
    check("rst_stack_err", {3'b0, stack_err}, 4'b0000);

    // 2: plain flag latch, trap disabled
    alu(16'h8000, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    clr();
    check("latch_flags", flags, 4'b1110);
    check("latch_no_req", {3'b0, irq_req}, 4'b0000);
    step();
    check("latch_hold", flags, 4'b1110);

    // 3: trap handshake
    alu(16'h8000, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    clr();
    check("trap_req_rise", {3'b0, irq_req}, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      step();
      check("trap_req_held", {3'b0, irq_req}, 4'b0001);
    end
    irq_ack = 1'b1;
    step();
    clr();
    check("ack_req_fall", {3'b0, irq_req}, 4'b0000);
    check("ack_in_handler", {3'b0, in_handler}, 4'b0001);
    sw_wr    = 1'b1;
    sw_wdata = 4'b0000;
    step();
    clr();
    check("svc_sw_clear", flags, 4'b0000);
    eret = 1'b1;
    step();
    clr();
    check("eret_restore", flags, 4'b1110);
    check("eret_in_handler", {3'b0, in_handler}, 4'b0000);
    check("eret_no_err", {3'b0, stack_err}, 4'b0000);

    // 4: nesting beyond STACK_DEPTH
    alu(16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    check("nest1_flags", flags, 4'b0101);
    check("nest1_req", {3'b0, irq_req}, 4'b0001);
    step();
    clr();
    check("nest1_absorb_req", {3'b0, irq_req}, 4'b0001);
    irq_ack = 1'b1;
    step();
    clr();
    check("nest1_svc", {3'b0, irq_req}, 4'b0000);
    alu(16'h8000, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    clr();
    check("nest2_req", {3'b0, irq_req}, 4'b0001);
    irq_ack = 1'b1;
    step();
    clr();
    check("nest2_no_err", {3'b0, stack_err}, 4'b0000);
    alu(16'h0000, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    clr();
    check("nest3_flags", flags, 4'b0110);
    irq_ack = 1'b1;
    step();
    clr();
    check("nest3_stack_err", {3'b0, stack_err}, 4'b0001);
    check("nest3_req_fall", {3'b0, irq_req}, 4'b0000);
    check("nest3_in_handler", {3'b0, in_handler}, 4'b0001);
    eret = 1'b1;
    step();
    check("pop1_flags", flags, 4'b1110);
    check("pop1_in_handler", {3'b0, in_handler}, 4'b0001);
    step();
    check("pop2_flags", flags, 4'b0101);
    check("pop2_in_handler", {3'b0, in_handler}, 4'b0000);
    step();
    clr();
    check("underflow_flags", flags, 4'b0101);
    check("underflow_err", {3'b0, stack_err}, 4'b0001);
    check("underflow_req", {3'b0, irq_req}, 4'b0000);
    do_reset();
    check("err_cleared", {3'b0, stack_err}, 4'b0000);

    // 5: write priority
    alu(16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
    sw_wr    = 1'b1;
    sw_wdata = 4'b0001;
    step();
    clr();
    check("sw_over_we", flags, 4'b0001);
    alu(16'h8000, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    clr();
    irq_ack = 1'b1;
    step();
    clr();
    check("prio_in_handler", {3'b0, in_handler}, 4'b0001);
    eret     = 1'b1;
    sw_wr    = 1'b1;
    sw_wdata = 4'b0011;
    step();
    clr();
    check("eret_over_sw", flags, 4'b1110);
    check("prio_back_idle", {3'b0, in_handler}, 4'b0000);

`ifdef ALU_FLAGS_STICKY_EN
    // 6: sticky overflow
    do_reset();
    check("sticky_rst", {3'b0, sticky_ovf}, 4'b0000);
    alu(16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    clr();
    check("sticky_set", {3'b0, sticky_ovf}, 4'b0001);
    check("sticky_no_req", {3'b0, irq_req}, 4'b0000);
    alu(16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    clr();
    check("sticky_survive", {3'b0, sticky_ovf}, 4'b0001);
    sw_wr    = 1'b1;
    sw_wdata = 4'b0000;
    step();
    clr();
    check("sticky_clear", {3'b0, sticky_ovf}, 4'b0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
